// File: rtl/execute_muldiv_ctrl_pkg.sv
// execute_pkg: shared width, op encodings and FSM states for the mul/div sequencer
package execute_pkg;
  localparam int XLEN = 32;
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;
endpackage

// File: rtl/execute_muldiv_ctrl_if.sv
// execute_muldiv_ctrl_if: EX-stage request inputs (start/op/rs/rt/mthi/mtlo/read_hilo/flush) and HI/LO/busy/done/stall outputs
interface execute_muldiv_ctrl_if;
  logic i_start, i_mthi, i_mtlo, i_read_hilo, i_flush;
  logic [1:0] i_op;
  logic [execute_pkg::XLEN-1:0] i_rs, i_rt, o_hi, o_lo;
  logic o_busy, o_done, o_stall;
  modport slave (input i_start, i_op, i_rs, i_rt, i_mthi, i_mtlo, i_read_hilo, i_flush,
                 output o_hi, o_lo, o_busy, o_done, o_stall);
  modport master (output i_start, i_op, i_rs, i_rt, i_mthi, i_mtlo, i_read_hilo, i_flush,
                  input o_hi, o_lo, o_busy, o_done, o_stall);
endinterface

// File: rtl/execute_muldiv_ctrl_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration; acc_i/op_i/is_div_i in, acc_o/q_o out
module muldiv_step
  import execute_pkg::*;
(
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   op_i,
  input  logic              is_div_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_o
);
  logic [XLEN:0] sum, dif;
  assign sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, op_i} : '0);
  // remainder shifted left with the next dividend bit; borrow means the divisor does not fit
  assign dif = acc_i[2*XLEN-1:XLEN-1] - {1'b0, op_i};
  assign q_o = is_div_i & ~dif[XLEN];
  assign acc_o = is_div_i ? {q_o ? dif[XLEN-1:0] : acc_i[2*XLEN-2:XLEN-1], acc_i[XLEN-2:0], 1'b0}
                          : {sum, acc_i[XLEN-1:1]};
endmodule

// File: rtl/execute_muldiv_ctrl.sv
// execute_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; clk, resetn (async low), bus (slave)
module execute_muldiv_ctrl
  import execute_pkg::*;
(
  input logic clk,
  input logic resetn,
  execute_muldiv_ctrl_if.slave bus
);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_d, prod;
  logic [XLEN-1:0] m_q, hi_q, lo_q, rs_abs, rt_abs, quo, rem;
  logic is_div_q, neg_q, neg_r, dz_q, done_q, q_bit, sgn, is_div;
  assign is_div = bus.i_op == OP_DIV || bus.i_op == OP_DIVU;
  assign sgn = bus.i_op == OP_MULT || bus.i_op == OP_DIV;
  assign rs_abs = (sgn & bus.i_rs[XLEN-1]) ? -bus.i_rs : bus.i_rs;
  assign rt_abs = (sgn & bus.i_rt[XLEN-1]) ? -bus.i_rt : bus.i_rt;
  muldiv_step u_step (.acc_i(acc_q), .op_i(m_q), .is_div_i(is_div_q), .acc_o(acc_d), .q_o(q_bit));
  assign prod = neg_q ? -acc_q : acc_q;
  // divide by zero: quotient is all ones; remainder equals |rs| so neg_r restores the original rs
  assign quo = dz_q ? '1 : neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem = neg_r ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      m_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      is_div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.i_flush) state_q <= S_IDLE;
      else case (state_q)
        S_IDLE: if (bus.i_start) begin
          state_q <= S_RUN;
          cnt_q <= '0;
          is_div_q <= is_div;
          neg_q <= sgn & (bus.i_rs[XLEN-1] ^ bus.i_rt[XLEN-1]);
          neg_r <= sgn & bus.i_rs[XLEN-1];
          dz_q <= bus.i_rt == '0;
          m_q <= is_div ? rt_abs : rs_abs;
          acc_q <= {{XLEN{1'b0}}, is_div ? rs_abs : rt_abs};
        end else begin
          if (bus.i_mthi) hi_q <= bus.i_rs;
          if (bus.i_mtlo) lo_q <= bus.i_rs;
        end
        S_RUN: begin
          acc_q <= {acc_d[2*XLEN-1:1], acc_d[0] | q_bit};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q <= is_div_q ? rem : prod[2*XLEN-1:XLEN];
          lo_q <= is_div_q ? quo : prod[XLEN-1:0];
          done_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.o_hi = hi_q;
  assign bus.o_lo = lo_q;
  assign bus.o_busy = state_q != S_IDLE;
  assign bus.o_done = done_q;
  assign bus.o_stall = bus.o_busy & (bus.i_start | bus.i_read_hilo | bus.i_mthi | bus.i_mtlo);
endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// tb_execute_muldiv_ctrl: scoreboard bench for the mul/div sequencer
module tb_execute_muldiv_ctrl;
  import execute_pkg::*;
  logic clk = 1'b0, resetn = 1'b0;
  int checks = 0, errors = 0;
  logic [63:0] sb[$];
  logic [63:0] last;
  execute_muldiv_ctrl_if bus();
  execute_muldiv_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb2 = longint'($signed(b));
    if (op[1] && b == 0) return {a, 32'hFFFFFFFF};
    case (op)
      2'b00: p = sa * sb2;
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        q = sa / sb2;
        r = sa % sb2;
        p = {r[31:0], q[31:0]};
      end
      default: p = {a % b, a / b};
    endcase
    return p;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt, input int rd_from);
    int n, ns;
    logic [63:0] e;
    sb.push_back(model(op, rs, rt));
    bus.i_op = op; bus.i_rs = rs; bus.i_rt = rt; bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    n = 0; ns = 0;
    while (bus.o_busy && n < 100) begin
      if (rd_from >= 0 && n >= rd_from) begin
        bus.i_read_hilo = 1'b1;
        #1;
        if (bus.o_stall) ns++;
      end
      n++;
      @(posedge clk); #1;
    end
    chk("latency", 64'(n), 64'd33);
    chk("done", 64'(bus.o_done), 64'd1);
    e = sb.pop_front();
    last = e;
    chk("hilo", {bus.o_hi, bus.o_lo}, e);
    if (rd_from >= 0) begin
      chk("stall_end", 64'(bus.o_stall), 64'd0);
      chk("stall_cycles", 64'(ns), 64'(33 - rd_from));
      bus.i_read_hilo = 1'b0;
    end
    @(posedge clk); #1;
    chk("done_pulse", 64'(bus.o_done), 64'd0);
  endtask

  initial begin
    bus.i_start = 0; bus.i_op = 0; bus.i_rs = 0; bus.i_rt = 0;
    bus.i_mthi = 0; bus.i_mtlo = 0; bus.i_read_hilo = 0; bus.i_flush = 0;
    last = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
    chk("rst_ctl", {61'd0, bus.o_busy, bus.o_done, bus.o_stall}, 64'd0);
    run_op(OP_MULT, 32'hFFFFFFFE, 32'h00000003, -1);
    chk("mult_exp", last, 64'hFFFFFFFF_FFFFFFFA);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    chk("multu_exp", last, 64'hFFFFFFFE_00000001);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, -1);
    chk("div_exp", last, 64'hFFFFFFFF_FFFFFFFD);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1);
    chk("divovf_exp", last, 64'h00000000_80000000);
    run_op(OP_DIVU, 32'd5, 32'd0, -1);
    chk("divz_exp", last, 64'h00000005_FFFFFFFF);
    run_op(OP_DIV, 32'hFFFFFF00, 32'd0, -1);
    run_op(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 5);
    for (int i = 0; i < 6; i++)
      run_op(2'($urandom_range(3)), $urandom, (i == 5) ? 32'h0000_0007 : $urandom, -1);
    // flush after E10 of a new op
    bus.i_op = OP_MULT; bus.i_rs = 32'd77; bus.i_rt = 32'd99; bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    chk("flush_busy", 64'(bus.o_busy), 64'd0);
    chk("flush_done", 64'(bus.o_done), 64'd0);
    chk("flush_hilo", {bus.o_hi, bus.o_lo}, last);
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.o_done) chk("flush_nodone", 64'(bus.o_done), 64'd0);
    end
    chk("flush_hilo2", {bus.o_hi, bus.o_lo}, last);
    // MTHI / MTLO in IDLE
    bus.i_rs = 32'h00001234; bus.i_mthi = 1'b1;
    @(posedge clk); #1;
    bus.i_mthi = 1'b0;
    last[63:32] = 32'h00001234;
    chk("mthi", {bus.o_hi, bus.o_lo}, last);
    bus.i_rs = 32'hCAFEF00D; bus.i_mthi = 1'b1; bus.i_mtlo = 1'b1; bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    chk("flush_mt", {bus.o_hi, bus.o_lo}, last);
    @(posedge clk); #1;
    bus.i_mthi = 1'b0; bus.i_mtlo = 1'b0;
    last = {2{32'hCAFEF00D}};
    chk("mthilo", {bus.o_hi, bus.o_lo}, last);
    // mthi together with start is ignored
    bus.i_mthi = 1'b1;
    run_op(OP_MULTU, 32'd6, 32'd7, -1);
    bus.i_mthi = 1'b0;
    // reset in the middle of RUN
    bus.i_op = OP_DIVU; bus.i_rs = 32'd1000; bus.i_rt = 32'd3; bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("mrst_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
    chk("mrst_ctl", {61'd0, bus.o_busy, bus.o_done, bus.o_stall}, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.o_done || bus.o_busy) chk("mrst_idle", {62'd0, bus.o_busy, bus.o_done}, 64'd0);
    end
    run_op(OP_DIV, 32'hFFFFFF9C, 32'h00000007, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
